// File: rtl/fpu_issue_if.sv
// fpu_issue_if: core command, FPU request/result and writeback bundle for fpu_issue_unit
// master (issue unit) drives cmd_ready, fpu_* request fields, fpu_cpu_ready, wb_*, status flags
// slave (core + wrapper side) drives cmd_*, fpu_ready, fpu_result_valid/tag_out/result, wb_ready
interface fpu_issue_if #(parameter int MAN_WIDTH = 24, parameter int EXP_WIDTH = 8, parameter int RD_WIDTH = 5);
  localparam int W = MAN_WIDTH + EXP_WIDTH;
  logic cmd_valid, cmd_ready;
  logic [2:0] cmd_op, cmd_rm;
  logic [RD_WIDTH-1:0] cmd_rd;
  logic [W-1:0] cmd_a, cmd_b;
  logic fpu_in_valid, fpu_ready;
  logic [3:0] fpu_tag;
  logic [2:0] fpu_operator, fpu_rounding_mode;
  logic [W-1:0] fpu_op1, fpu_op2;
  logic fpu_result_valid, fpu_cpu_ready;
  logic [3:0] fpu_tag_out;
  logic [W-1:0] fpu_result;
  logic wb_valid, wb_ready;
  logic [RD_WIDTH-1:0] wb_rd;
  logic [W-1:0] wb_data;
  logic [4:0] outstanding;
  logic cmd_illegal, spurious_tag;
  modport master(
    input cmd_valid, cmd_op, cmd_rm, cmd_rd, cmd_a, cmd_b, fpu_ready,
    input fpu_result_valid, fpu_tag_out, fpu_result, wb_ready,
    output cmd_ready, fpu_in_valid, fpu_tag, fpu_operator, fpu_rounding_mode, fpu_op1, fpu_op2,
    output fpu_cpu_ready, wb_valid, wb_rd, wb_data, outstanding, cmd_illegal, spurious_tag
  );
  modport slave(
    output cmd_valid, cmd_op, cmd_rm, cmd_rd, cmd_a, cmd_b, fpu_ready,
    output fpu_result_valid, fpu_tag_out, fpu_result, wb_ready,
    input cmd_ready, fpu_in_valid, fpu_tag, fpu_operator, fpu_rounding_mode, fpu_op1, fpu_op2,
    input fpu_cpu_ready, wb_valid, wb_rd, wb_data, outstanding, cmd_illegal, spurious_tag
  );
endinterface

// File: rtl/fpu_issue_unit.sv
// fpu_issue_unit: tags FP commands, drives the FPU request handshake, routes tagged results to writeback
// clk, reset: single clock, synchronous active-high reset
// io (fpu_issue_if.master): command port, FPU request/result port, writeback port, status flags
module fpu_issue_unit #(
  parameter int MAN_WIDTH = 24,
  parameter int EXP_WIDTH = 8,
  parameter int NUM_TAGS = 16,
  parameter int RD_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  fpu_issue_if.master io
);
  localparam int W = MAN_WIDTH + EXP_WIDTH;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q;
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [RD_WIDTH-1:0] rd_q [NUM_TAGS];
  logic [RD_WIDTH-1:0] hit_rd;
  logic [3:0] tag_q, alloc;
  logic [2:0] op_q, rm_q;
  logic [W-1:0] a_q, b_q;
  logic [4:0] cnt;
  logic ill_q, spur_q, have_free, waw, hit, legal, slot, acc, acc_legal, xfer;
  // Table scan over registered state only: lowest free tag, WAW match, result lookup, popcount
  always_comb begin
    alloc = '0;
    have_free = 1'b0;
    waw = 1'b0;
    hit = 1'b0;
    hit_rd = '0;
    cnt = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      alloc = valid_q[t] ? alloc : 4'(t);
      have_free = have_free | ~valid_q[t];
      waw = waw | (valid_q[t] & (rd_q[t] == io.cmd_rd));
      hit = hit | (valid_q[t] & (io.fpu_tag_out == 4'(t)));
      hit_rd = (io.fpu_tag_out == 4'(t)) ? rd_q[t] : hit_rd;
      cnt = cnt + 5'(valid_q[t]);
    end
  end
  assign legal = io.cmd_op <= 3'd4;
  assign slot = (state_q == IDLE) | io.fpu_ready;
  // Illegal ops only need the request slot; they never take a tag
  assign io.cmd_ready = ~reset & slot & (~legal | (have_free & ~waw));
  assign acc = io.cmd_valid & io.cmd_ready;
  assign acc_legal = acc & legal;
  // Misses are always drained so a stray tag can never wedge the wrapper
  assign io.fpu_cpu_ready = io.wb_ready | ~hit;
  assign xfer = io.fpu_result_valid & io.fpu_cpu_ready & hit;
  always_comb begin
    valid_d = valid_q;
    for (int t = 0; t < NUM_TAGS; t++)
      valid_d[t] = (valid_q[t] & ~(xfer & (io.fpu_tag_out == 4'(t)))) | (acc_legal & (alloc == 4'(t)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      tag_q <= '0;
      op_q <= '0;
      rm_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ill_q <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ill_q <= acc & ~legal;
      spur_q <= spur_q | (io.fpu_result_valid & ~hit);
      for (int t = 0; t < NUM_TAGS; t++)
        if (acc_legal && alloc == 4'(t)) rd_q[t] <= io.cmd_rd;
      if (acc_legal) begin
        state_q <= REQ;
        tag_q <= alloc;
        op_q <= io.cmd_op;
        rm_q <= io.cmd_rm;
        a_q <= io.cmd_a;
        b_q <= io.cmd_b;
      end else if (io.fpu_ready) state_q <= IDLE;
    end
  end
  assign io.fpu_in_valid = state_q == REQ;
  assign io.fpu_tag = tag_q;
  assign io.fpu_operator = op_q;
  assign io.fpu_rounding_mode = rm_q;
  assign io.fpu_op1 = a_q;
  assign io.fpu_op2 = b_q;
  assign io.wb_valid = io.fpu_result_valid & hit;
  assign io.wb_rd = hit_rd;
  assign io.wb_data = io.fpu_result;
  assign io.outstanding = cnt;
  assign io.cmd_illegal = ill_q;
  assign io.spurious_tag = spur_q;
endmodule

// File: tb/tb_fpu_issue_unit.sv
// tb_fpu_issue_unit: randomized and directed scoreboard bench for fpu_issue_unit
module tb_fpu_issue_unit;
  localparam int NT = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nchk = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  fpu_issue_if #(.MAN_WIDTH(24), .EXP_WIDTH(8), .RD_WIDTH(5)) b();
  fpu_issue_unit #(.MAN_WIDTH(24), .EXP_WIDTH(8), .NUM_TAGS(NT), .RD_WIDTH(5)) dut(.clk(clk), .reset(reset), .io(b.master));
  typedef struct packed {logic [3:0] tag; logic [2:0] op; logic [2:0] rm; logic [31:0] a; logic [31:0] bb;} req_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} wb_t;
  req_t req_q[$];
  wb_t wb_q[$];
  bit m_alloc [NT];
  logic [4:0] m_rd [NT];
  bit m_pend = 0, m_ill = 0, m_spur = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // Reference model: tag table as arrays, decisions straight from the command/result rules
  always @(negedge clk) begin
    int low, cnt;
    bit waw, legal, hit, rdy;
    low = -1;
    cnt = 0;
    waw = 0;
    for (int t = NT - 1; t >= 0; t--)
      if (!m_alloc[t]) low = t;
      else begin
        cnt++;
        if (m_rd[t] == b.cmd_rd) waw = 1;
      end
    legal = b.cmd_op <= 3'd4;
    rdy = !reset && (!m_pend || b.fpu_ready) && (!legal || (low >= 0 && !waw));
    hit = m_alloc[b.fpu_tag_out];
    chk("cmd_ready", b.cmd_ready, rdy);
    chk("fpu_in_valid", b.fpu_in_valid, m_pend);
    chk("outstanding", b.outstanding, cnt);
    chk("cmd_illegal", b.cmd_illegal, m_ill);
    chk("spurious_tag", b.spurious_tag, m_spur);
    chk("wb_valid", b.wb_valid, b.fpu_result_valid && hit);
    chk("fpu_cpu_ready", b.fpu_cpu_ready, b.wb_ready || !hit);
    if (reset) begin
      for (int t = 0; t < NT; t++) m_alloc[t] = 0;
      m_pend = 0;
      m_ill = 0;
      m_spur = 0;
      req_q.delete();
      wb_q.delete();
    end else begin
      if (b.fpu_result_valid && hit && b.wb_ready) begin
        wb_q.push_back('{rd: m_rd[b.fpu_tag_out], d: b.fpu_result});
        m_alloc[b.fpu_tag_out] = 0;
      end
      if (b.fpu_result_valid && !hit) m_spur = 1;
      m_ill = b.cmd_valid && rdy && !legal;
      if (b.fpu_ready) m_pend = 0;
      if (b.cmd_valid && rdy && legal) begin
        m_alloc[low] = 1;
        m_rd[low] = b.cmd_rd;
        m_pend = 1;
        req_q.push_back('{tag: 4'(low), op: b.cmd_op, rm: b.cmd_rm, a: b.cmd_a, bb: b.cmd_b});
      end
    end
  end
  // Monitor: checks whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    req_t r;
    wb_t w;
    #1;
    if (!reset && b.fpu_in_valid) begin
      chk("req_expected", req_q.size() != 0, 1);
      if (req_q.size() != 0) begin
        r = req_q[0];
        chk("fpu_tag", b.fpu_tag, r.tag);
        chk("fpu_operator", b.fpu_operator, r.op);
        chk("fpu_rm", b.fpu_rounding_mode, r.rm);
        chk("fpu_op1", b.fpu_op1, r.a);
        chk("fpu_op2", b.fpu_op2, r.bb);
        if (b.fpu_ready) void'(req_q.pop_front());
      end
    end
    if (!reset && b.wb_valid && b.wb_ready) begin
      chk("wb_expected", wb_q.size() != 0, 1);
      if (wb_q.size() != 0) begin
        w = wb_q.pop_front();
        chk("wb_rd", b.wb_rd, w.rd);
        chk("wb_data", b.wb_data, w.d);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] bb, input int n, output bit acc);
    b.cmd_valid = 1;
    b.cmd_op = op;
    b.cmd_rm = 3'($urandom);
    b.cmd_rd = rd;
    b.cmd_a = a;
    b.cmd_b = bb;
    acc = 0;
    for (int i = 0; i < n && !acc; i++) begin
      @(negedge clk);
      acc = b.cmd_ready;
      tick();
    end
    b.cmd_valid = 0;
  endtask
  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] bb);
    bit acc;
    hold(op, rd, a, bb, 50, acc);
    chk("issue_accept", acc, 1);
  endtask
  task automatic ret(input logic [3:0] tag, input logic [31:0] d);
    bit x = 0;
    b.fpu_result_valid = 1;
    b.fpu_tag_out = tag;
    b.fpu_result = d;
    for (int i = 0; i < 50 && !x; i++) begin
      @(negedge clk);
      x = b.fpu_cpu_ready;
      tick();
    end
    b.fpu_result_valid = 0;
    chk("result_xfer", x, 1);
  endtask
  initial begin
    bit acc;
    b.cmd_valid = 0; b.cmd_op = 0; b.cmd_rm = 0; b.cmd_rd = 0; b.cmd_a = 0; b.cmd_b = 0;
    b.fpu_ready = 1; b.fpu_result_valid = 0; b.fpu_tag_out = 0; b.fpu_result = 0; b.wb_ready = 1;
    repeat (3) tick();
    reset = 0;
    chk("rst_tag", b.fpu_tag, 0);
    chk("rst_op", b.fpu_operator, 0);
    chk("rst_rm", b.fpu_rounding_mode, 0);
    chk("rst_op1", b.fpu_op1, 0);
    chk("rst_op2", b.fpu_op2, 0);
    issue(3'b000, 5'd3, 32'h3F800000, 32'h40000000);
    chk("add_out", b.outstanding, 1);
    ret(4'd0, 32'h40400000);
    chk("add_free", b.outstanding, 0);
    b.fpu_ready = 0;
    issue(3'b010, 5'd1, $urandom, $urandom);
    hold(3'b000, 5'd2, $urandom, $urandom, 5, acc);
    chk("stall_not_ready", acc, 0);
    b.fpu_ready = 1;
    issue(3'b000, 5'd2, $urandom, $urandom);
    ret(4'd0, $urandom);
    ret(4'd1, $urandom);
    for (int i = 0; i < NT; i++) issue(3'($urandom_range(0, 4)), 5'(i), $urandom, $urandom);
    chk("full_out", b.outstanding, NT);
    hold(3'b001, 5'd20, $urandom, $urandom, 3, acc);
    chk("full_stall", acc, 0);
    ret(4'd7, $urandom);
    hold(3'b001, 5'd20, $urandom, $urandom, 1, acc);
    chk("full_reuse", acc, 1);
    for (int t = 0; t < NT; t++) ret(4'(t), $urandom);
    chk("drain_out", b.outstanding, 0);
    issue(3'b011, 5'd4, $urandom, $urandom);
    hold(3'b000, 5'd4, $urandom, $urandom, 3, acc);
    chk("waw_stall", acc, 0);
    issue(3'b000, 5'd5, $urandom, $urandom);
    ret(4'd0, $urandom);
    issue(3'b000, 5'd4, $urandom, $urandom);
    ret(4'd0, $urandom);
    ret(4'd1, $urandom);
    issue(3'b100, 5'd6, $urandom, $urandom);
    b.wb_ready = 0;
    b.fpu_result_valid = 1;
    b.fpu_tag_out = 0;
    b.fpu_result = $urandom;
    repeat (3) tick();
    chk("wb_hold_out", b.outstanding, 1);
    b.wb_ready = 1;
    tick();
    b.fpu_result_valid = 0;
    chk("wb_done_out", b.outstanding, 0);
    ret(4'd9, $urandom);
    chk("spurious", b.spurious_tag, 1);
    hold(3'b111, 5'd8, $urandom, $urandom, 3, acc);
    chk("illegal_accept", acc, 1);
    tick();
    for (int i = 0; i < 3; i++) issue(3'b010, 5'(10 + i), $urandom, $urandom);
    chk("pre_rst_out", b.outstanding, 3);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_out", b.outstanding, 0);
    for (int c = 0; c < 3000; c++) begin
      int t;
      reset = $urandom_range(0, 499) == 0;
      b.cmd_valid = $urandom_range(0, 2) != 0;
      b.cmd_op = $urandom_range(0, 9) == 0 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      b.cmd_rm = 3'($urandom);
      b.cmd_rd = 5'($urandom_range(0, 7));
      b.cmd_a = $urandom;
      b.cmd_b = $urandom;
      b.fpu_ready = $urandom_range(0, 3) != 0;
      b.wb_ready = $urandom_range(0, 3) != 0;
      t = $urandom_range(0, NT - 1);
      b.fpu_tag_out = 4'(t);
      b.fpu_result = $urandom;
      b.fpu_result_valid = (m_alloc[t] && $urandom_range(0, 1) == 0) || $urandom_range(0, 63) == 0;
      @(posedge clk);
      #1;
    end
    reset = 0;
    b.cmd_valid = 0;
    b.fpu_result_valid = 0;
    b.fpu_ready = 1;
    repeat (3) tick();
    chk("req_drained", req_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fpu_issue_unit.md
# fpu_issue_unit

Core-side initiator for the FPU wrapper's request/result protocol. It accepts FP commands from the integer pipeline, assigns each a free 4-bit tag, and drives the FPU request handshake (in_valid/fpu_ready). It then matches returning tagged results (result_valid/cpu_ready) back to their destination register and presents them on a writeback port. It sits between the core decode/issue stage and the FPU wrapper and owns all tag bookkeeping.

## Interface
Parameters:
- MAN_WIDTH, 24, mantissa width incl. hidden bit; W = MAN_WIDTH+EXP_WIDTH
- EXP_WIDTH, 8, exponent width
- NUM_TAGS, 16, tags in use, 1..16; tags 0..NUM_TAGS-1
- RD_WIDTH, 5, destination register index width

Ports (one clock; reset synchronous, active-high):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  core command valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt; others illegal
- cmd_rm  in  3  rounding mode, passed through
- cmd_rd  in  RD_WIDTH  destination register
- cmd_a, cmd_b  in  W  IEEE operands (cmd_b ignored by sqrt, still forwarded)
- fpu_in_valid  out  1  request valid (to wrapper in_valid)
- fpu_ready  in  1  wrapper fpu_ready
- fpu_tag  out  4  request tag
- fpu_operator  out  3  request op
- fpu_rounding_mode  out  3  request rounding mode
- fpu_op1, fpu_op2  out  W  request operands
- fpu_result_valid  in  1  wrapper result_valid
- fpu_tag_out  in  4  tag of returning result
- fpu_result  in  W  result data
- fpu_cpu_ready  out  1  to wrapper cpu_ready
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback accepted
- wb_rd  out  RD_WIDTH  writeback register
- wb_data  out  W  writeback data
- outstanding  out  5  allocated tag count
- cmd_illegal  out  1  one-cycle pulse: illegal op consumed
- spurious_tag  out  1  sticky: result arrived for unallocated tag

## Operation
- Tag table: per tag, valid bit + rd. Allocation at command acceptance; free at result transfer (fpu_result_valid&fpu_cpu_ready).
- Allocation picks lowest-numbered free tag, computed from registered table state; tag freed in cycle N is allocatable from N+1.
- WAW guard: command stalls while any valid entry holds rd == cmd_rd (registered state; entry being freed this cycle still blocks).
- Request register (req_pending + fields). cmd_ready = ~reset & (~req_pending | fpu_ready) & free_tag_exists & ~waw_hit. Illegal op: cmd_ready = ~req_pending | fpu_ready only; consumed with cmd_illegal pulse next cycle; no tag, no request.
- Request state machine: IDLE (fpu_in_valid=0) -> REQ on legal accept; REQ holds all fpu_* fields stable until fpu_ready; on fpu_ready with new legal accept same cycle stay REQ with new fields (back-to-back); otherwise -> IDLE.
- Result path combinational: hit = valid[fpu_tag_out]; wb_valid = fpu_result_valid & hit; wb_rd = rd[fpu_tag_out]; wb_data = fpu_result; fpu_cpu_ready = wb_ready | ~hit.
- Miss (fpu_result_valid & ~hit): result dropped (fpu_cpu_ready=1), spurious_tag set until reset.
- outstanding = popcount(valid); alloc and free same cycle leave it unchanged.

## Timing
- Reset values: cmd_ready 0 during reset, fpu_in_valid 0, fpu_tag/operator/rounding_mode/op1/op2 0, wb_valid 0 (table empty), outstanding 0, cmd_illegal 0, spurious_tag 0, all tags free.
- Accept at edge N -> fpu_in_valid high from cycle N+1; sustained throughput one request/cycle while fpu_ready=1 and tags free.
- Result to writeback: 0 cycles; tag freed at the transfer edge.
- Reset mid-operation: table, request register and flags clear at that edge; in-flight wrapper results after reset are treated as misses (FPU is reset concurrently, so none are expected).
- Full (outstanding==NUM_TAGS): cmd_ready=0 until a result transfers; accept possible the cycle after.

## Test plan
- Reset, single add 1.0+2.0 (0x3F800000,0x40000000) rd=3, fpu_ready=1 -> fpu_in_valid cycle after accept, fpu_tag=0, op=000; result 0x40400000 tag 0 -> wb_valid, wb_rd=3, wb_data=0x40400000, outstanding 1->0.
- fpu_ready held 0 for 5 cycles after request -> fpu_* fields stable, cmd_ready=0 on second command, transfer on cycle ready rises.
- Issue 16 commands rd=0..15 -> tags 0..15, outstanding=16, cmd_ready=0; return tag 7 -> next command gets tag 7 one cycle later.
- Command rd=4 pending, second command rd=4 -> stalls until first writes back; rd=5 accepted meanwhile.
- wb_ready=0 with valid result -> fpu_cpu_ready=0, tag stays allocated; result tag 9 unallocated -> fpu_cpu_ready=1, spurious_tag=1, no wb_valid.
- cmd_op=111 -> cmd_illegal one-cycle pulse, no fpu_in_valid, outstanding unchanged; reset asserted with 3 outstanding -> outstanding=0 next cycle.
